ff_test_sequencer: RTL and testbench

FF_TEST_SEQUENCER -- requirements
Module: ff_test_sequencer

---
 rtl/ff_test_sequencer_if.sv | 20 ++
 rtl/ff_test_sequencer.sv | 124 ++++++++++++
 tb/tb_ff_test_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ff_test_sequencer_if.sv
// Bundle between the flip-flop test sequencer, its host and the flip-flop bank.
// The master side (host/bench) drives the run request and the flip-flop outputs.
interface ff_test_sequencer_if;
  logic       start;
  logic [1:0] mode;
  logic       ff_rst;
  logic       d, j, k, t;
  logic       q_d, q_jk, q_t;
  logic       busy, done, pass;
  logic [2:0] err_step;

  modport master (
    output start, mode, q_d, q_jk, q_t,
    input  ff_rst, d, j, k, t, busy, done, pass, err_step
  );
  modport slave (
    input  start, mode, q_d, q_jk, q_t,
    output ff_rst, d, j, k, t, busy, done, pass, err_step
  );
endinterface

// File: rtl/ff_test_sequencer.sv
// Sequencer that resets a D/JK/T flip-flop bank, drives a fixed six-step
// stimulus table into the selected flip-flop and checks its Q after settling.
module ff_test_sequencer #(
  parameter int SETTLE_CYC = 2
) (
  input logic              clk,
  input logic              rst,
  ff_test_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_INIT_CHK, S_DRIVE, S_SETTLE, S_CHECK, S_DONE
  } state_t;

  // Step tables, bit s = step s.
  localparam logic [5:0] D_STIM  = 6'b001101;
  localparam logic [5:0] D_EXP   = 6'b001101;
  localparam logic [5:0] J_STIM  = 6'b101101;
  localparam logic [5:0] K_STIM  = 6'b001110;
  localparam logic [5:0] JK_EXP  = 6'b100101;
  localparam logic [5:0] T_STIM  = 6'b101101;
  localparam logic [5:0] T_EXP   = 6'b011011;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_mode;
  logic [2:0] r_step;
  logic [3:0] r_cnt;
  logic       r_pass;
  logic [2:0] r_err;
  logic       w_q_sel, w_exp, w_d_val;

  always_comb begin
    w_q_sel = 1'b0;
    w_exp   = 1'b0;
    w_d_val = 1'b0;
    case (r_mode)
      2'b00: begin w_q_sel = bus.q_d;  w_exp = D_EXP[r_step]; w_d_val = D_STIM[r_step]; end
      2'b01: begin w_q_sel = bus.q_jk; w_exp = JK_EXP[r_step]; end
      2'b10: begin w_q_sel = bus.q_t;  w_exp = T_EXP[r_step]; end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    bus.ff_rst   = 1'b0;
    bus.d        = 1'b0;
    bus.j        = 1'b0;
    bus.k        = 1'b0;
    bus.t        = 1'b0;
    bus.busy     = 1'b1;
    bus.done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) w_state_nxt = (bus.mode == 2'b11) ? S_DONE : S_INIT;
      end
      S_INIT: begin
        bus.ff_rst = 1'b1;
        if (r_cnt == 4'd1) w_state_nxt = S_INIT_CHK;
      end
      S_INIT_CHK: w_state_nxt = w_q_sel ? S_DONE : S_DRIVE;
      S_DRIVE: begin
        bus.d = w_d_val;
        bus.j = (r_mode == 2'b01) & J_STIM[r_step];
        bus.k = (r_mode == 2'b01) & K_STIM[r_step];
        bus.t = (r_mode == 2'b10) & T_STIM[r_step];
        w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        bus.d = w_d_val;
        if (r_cnt == 4'(SETTLE_CYC - 1)) w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        bus.d = w_d_val;
        w_state_nxt = ((w_q_sel != w_exp) || (r_step == 3'd5)) ? S_DONE : S_DRIVE;
      end
      S_DONE: begin
        bus.busy    = 1'b0;
        bus.done    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_mode  <= 2'b00;
      r_step  <= 3'd0;
      r_cnt   <= 4'd0;
      r_pass  <= 1'b0;
      r_err   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      // r_cnt times both the INIT hold and the SETTLE hold.
      if (r_state != w_state_nxt)                      r_cnt <= 4'd0;
      else if (r_state == S_INIT || r_state == S_SETTLE) r_cnt <= r_cnt + 4'd1;
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_mode <= bus.mode;
          r_pass <= 1'b0;
          r_err  <= (bus.mode == 2'b11) ? 3'd6 : 3'd0;
        end
        S_INIT_CHK: if (w_q_sel) r_err <= 3'd7;
        S_CHECK: begin
          if (w_q_sel != w_exp) begin
            r_err  <= r_step;
            r_step <= 3'd0;
          end else if (r_step == 3'd5) begin
            r_pass <= 1'b1;
            r_step <= 3'd0;
          end else begin
            r_step <= r_step + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pass     = r_pass;
  assign bus.err_step = r_err;
endmodule

// File: tb/tb_ff_test_sequencer.sv
// Bench for ff_test_sequencer: behavioural flip-flop bank with injectable faults,
// vector table, randomized runs against a reference model, and reset corner cases.
module tb_ff_test_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   fault;  // 0 none, 1 JK holds on 11, 2 T stuck, 3 q_d forced high
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ff_test_sequencer_if bus();
  ff_test_sequencer #(.SETTLE_CYC(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Flip-flop bank under test
  logic qd_r, qjk_r, qt_r;
  always @(posedge clk) begin
    if (bus.ff_rst) begin
      qd_r <= 1'b0; qjk_r <= 1'b0; qt_r <= 1'b0;
    end else begin
      qd_r <= bus.d;
      if (bus.j && bus.k) qjk_r <= (fault == 1) ? qjk_r : ~qjk_r;
      else if (bus.j)     qjk_r <= 1'b1;
      else if (bus.k)     qjk_r <= 1'b0;
      if (bus.t && fault != 2) qt_r <= ~qt_r;
    end
  end
  assign bus.q_d  = (fault == 3) ? 1'b1 : qd_r;
  assign bus.q_jk = qjk_r;
  assign bus.q_t  = qt_r;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Reference: walk the step tables with an abstract flip-flop and find the
  // first mismatching step; done lands 4 cycles per step after the init check.
  task automatic ref_run(input int m, input int f, output int dk, output int p, output int e);
    int ds[6]  = '{1,0,1,1,0,0};
    int js[6]  = '{1,0,1,1,0,1};
    int ks[6]  = '{0,1,1,1,0,0};
    int ts[6]  = '{1,0,1,1,0,1};
    int xd[6]  = '{1,0,1,1,0,0};
    int xjk[6] = '{1,0,1,0,0,1};
    int xt[6]  = '{1,1,0,1,1,0};
    int q = 0;
    int x;
    if (m == 3) begin dk = 1; p = 0; e = 6; return; end
    if (m == 0 && f == 3) begin dk = 4; p = 0; e = 7; return; end
    for (int s = 0; s < 6; s++) begin
      if (m == 0) begin q = ds[s]; x = xd[s]; end
      else if (m == 1) begin
        if (js[s] == 1 && ks[s] == 1) q = (f == 1) ? q : 1 - q;
        else if (js[s] == 1) q = 1;
        else if (ks[s] == 1) q = 0;
        x = xjk[s];
      end else begin
        if (ts[s] == 1 && f != 2) q = 1 - q;
        x = xt[s];
      end
      if (q != x) begin dk = 8 + 4*s; p = 0; e = s; return; end
    end
    dk = 28; p = 1; e = 0;
  endtask

  // One run: start at edge N, k counts cycles N+k observed at negedge.
  task automatic run(input int m, input bit poke, output int dk, output int p, output int e,
                     output int nbusy, output int nffrst, output int after);
    @(negedge clk);
    bus.mode = 2'(m); bus.start = 1'b1;
    dk = -1; p = -1; e = -1; nbusy = 0; nffrst = 0;
    for (int kk = 1; kk <= 100; kk++) begin
      @(negedge clk);
      bus.start = poke && (kk == 5 || kk == 10 || kk == 20);
      bus.mode  = poke ? 2'b11 : 2'(m);
      if (bus.busy)   nbusy++;
      if (bus.ff_rst) nffrst++;
      if (bus.done) begin dk = kk; p = bus.pass; e = bus.err_step; break; end
    end
    bus.start = 1'b0;
    @(negedge clk);
    after = {bus.done, bus.busy};
  endtask

  typedef struct { int m; int f; int dk; int p; int e; } vec_t;
  vec_t vecs[8];

  initial begin
    int dk, p, e, nb, nf, af, rdk, rp, re, m, f;
    bit seen;
    vecs[0] = '{0, 0, 28, 1, 0};
    vecs[1] = '{1, 0, 28, 1, 0};
    vecs[2] = '{2, 0, 28, 1, 0};
    vecs[3] = '{3, 0,  1, 0, 6};
    vecs[4] = '{1, 1, 16, 0, 2};
    vecs[5] = '{2, 2,  8, 0, 0};
    vecs[6] = '{0, 3,  4, 0, 7};
    vecs[7] = '{2, 1, 28, 1, 0};

    fault = 0; rst = 1'b0; bus.start = 1'b0; bus.mode = 2'b00;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {bus.busy, bus.done, bus.pass, bus.ff_rst, bus.d, bus.j, bus.k, bus.t, bus.err_step}, 0);
    rst = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      fault = vecs[i].f;
      run(vecs[i].m, 1'b0, dk, p, e, nb, nf, af);
      chk($sformatf("vec%0d_done_cycle", i), dk, vecs[i].dk);
      chk($sformatf("vec%0d_pass", i), p, vecs[i].p);
      chk($sformatf("vec%0d_err_step", i), e, vecs[i].e);
      chk($sformatf("vec%0d_busy_cycles", i), nb, vecs[i].dk - 1);
      chk($sformatf("vec%0d_ff_rst_cycles", i), nf, (vecs[i].m == 3) ? 0 : 2);
      chk($sformatf("vec%0d_done_one_cycle", i), af, 0);
      repeat (2) @(negedge clk);
      chk($sformatf("vec%0d_result_hold", i), {bus.pass, bus.err_step}, {vecs[i].p[0], vecs[i].e[2:0]});
    end

    for (int r = 0; r < 20; r++) begin
      m = $urandom_range(0, 3); f = $urandom_range(0, 3);
      fault = f;
      ref_run(m, f, rdk, rp, re);
      run(m, 1'b0, dk, p, e, nb, nf, af);
      chk($sformatf("rnd%0d_m%0d_f%0d_done_cycle", r, m, f), dk, rdk);
      chk($sformatf("rnd%0d_m%0d_f%0d_result", r, m, f), p * 8 + e, rp * 8 + re);
    end

    // Reset during the step-3 SETTLE (cycle N+17): abort, no done.
    fault = 0;
    @(negedge clk);
    bus.mode = 2'b00; bus.start = 1'b1;
    for (int kk = 1; kk <= 17; kk++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    chk("midrun_busy_before_reset", bus.busy, 1);
    chk("midrun_d_step3_hold", bus.d, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrun_reset_outputs", {bus.busy, bus.done, bus.pass, bus.ff_rst, bus.d, bus.j, bus.k, bus.t, bus.err_step}, 0);
    rst = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen = 1'b1;
    end
    chk("midrun_no_done_after_abort", seen, 0);

    // Reset wins over start in the same cycle.
    rst = 1'b0; bus.start = 1'b1; bus.mode = 2'b00;
    @(negedge clk);
    rst = 1'b1; bus.start = 1'b0;
    @(negedge clk);
    chk("rst_priority_over_start", bus.busy, 0);

    // Start pulses while busy must not disturb the run.
    run(2, 1'b1, dk, p, e, nb, nf, af);
    chk("busy_start_done_cycle", dk, 28);
    chk("busy_start_result", p * 8 + e, 8);
    chk("busy_start_idle_after", af, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
